snake_body_engine: RTL and testbench

- Parametrised snake game-state engine; successor to the single-rectangle mover in the snake top level.
- Holds the snake as a circular segment buffer on a GRID_W x GRID_H cell grid and steps it once per frame tick, steered by PS/2 arrow key codes.
- Detects wall and self collisions, grows on request, and supports pause and restart.
- Exposes a registered segment read port that the pixel renderer scans.

---
 rtl/snake_body_engine.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
`default_nettype none
// ============================================================================
// Module  : snake_body_engine
// Brief   : Snake game state in a circular segment buffer, stepped once per
//           frame tick with wall/self collision checks and a registered read port.
// Rev     : 1.0
// ============================================================================
module snake_body_engine #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int X_W      = 6,
    parameter int Y_W      = 6,
    parameter int L_W      = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_tick,
    input  logic           i_key_valid,
    input  logic [7:0]     i_key_code,
    input  logic           i_grow,
    input  logic [L_W-1:0] i_rd_idx,
    output logic [X_W-1:0] o_rd_x,
    output logic [Y_W-1:0] o_rd_y,
    output logic           o_rd_valid,
    output logic [X_W-1:0] o_head_x,
    output logic [Y_W-1:0] o_head_y,
    output logic [L_W-1:0] o_length,
    output logic           o_running,
    output logic           o_dead,
    output logic           o_busy,
    output logic           o_step_done,
    output logic           o_overrun
);

    localparam int P_W = $clog2(MAX_LEN);

    localparam logic [2:0] c_ST_INIT   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_CHECK  = 3'd3;
    localparam logic [2:0] c_ST_COMMIT = 3'd4;
    localparam logic [2:0] c_ST_PAUSE  = 3'd5;
    localparam logic [2:0] c_ST_DEAD   = 3'd6;

    // Opposite directions differ only in bit 0.
    localparam logic [1:0] c_DIR_RIGHT = 2'd0;
    localparam logic [1:0] c_DIR_LEFT  = 2'd1;
    localparam logic [1:0] c_DIR_DOWN  = 2'd2;
    localparam logic [1:0] c_DIR_UP    = 2'd3;

    localparam logic [7:0] c_KEY_RIGHT = 8'h74;
    localparam logic [7:0] c_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] c_KEY_DOWN  = 8'h72;
    localparam logic [7:0] c_KEY_UP    = 8'h75;
    localparam logic [7:0] c_KEY_SPACE = 8'h29;
    localparam logic [7:0] c_KEY_ENTER = 8'h5A;

    localparam logic [X_W-1:0] c_CX      = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0] c_CY      = Y_W'(GRID_H / 2);
    localparam logic [X_W-1:0] c_X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] c_Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [L_W-1:0] c_MAX_LEN = L_W'(MAX_LEN);
    localparam logic [L_W-1:0] c_INIT_LAST = L_W'(INIT_LEN - 1);

    logic [X_W-1:0] r_mem_x [MAX_LEN];
    logic [Y_W-1:0] r_mem_y [MAX_LEN];

    logic [2:0]     r_state;
    logic [P_W-1:0] r_head_ptr;
    logic [L_W-1:0] r_length;
    logic [1:0]     r_dir;
    logic [1:0]     r_next_dir;
    logic           r_grow_pend;
    logic [L_W-1:0] r_init_cnt;
    logic [L_W-1:0] r_scan;
    logic [X_W-1:0] r_nh_x;
    logic [Y_W-1:0] r_nh_y;
    logic [X_W-1:0] r_head_x;
    logic [Y_W-1:0] r_head_y;
    logic [X_W-1:0] r_chk_x;
    logic [Y_W-1:0] r_chk_y;
    logic [X_W-1:0] r_rd_x;
    logic [Y_W-1:0] r_rd_y;
    logic           r_rd_valid;
    logic           r_step_done;
    logic           r_overrun;
    logic           r_busy;
    logic           r_running;
    logic           r_dead;

    logic [2:0]     w_state_nxt;
    logic           w_key_is_dir;
    logic [1:0]     w_key_dir;
    logic           w_key_ok;
    logic           w_key_space;
    logic           w_key_enter;
    logic [X_W-1:0] w_nh_x;
    logic [Y_W-1:0] w_nh_y;
    logic           w_wall;
    logic           w_grow_ok;
    logic [L_W-1:0] w_span;
    logic           w_hit;
    logic           w_busy;
    logic           w_wr_en;
    logic [P_W-1:0] w_wr_addr;
    logic [X_W-1:0] w_wr_x;
    logic [Y_W-1:0] w_wr_y;
    logic [P_W-1:0] w_chk_addr;
    logic [P_W-1:0] w_rd_addr;

    always_comb begin
        w_key_is_dir = 1'b0;
        w_key_dir    = c_DIR_RIGHT;
        case (i_key_code)
            c_KEY_RIGHT: begin w_key_is_dir = 1'b1; w_key_dir = c_DIR_RIGHT; end
            c_KEY_LEFT:  begin w_key_is_dir = 1'b1; w_key_dir = c_DIR_LEFT;  end
            c_KEY_DOWN:  begin w_key_is_dir = 1'b1; w_key_dir = c_DIR_DOWN;  end
            c_KEY_UP:    begin w_key_is_dir = 1'b1; w_key_dir = c_DIR_UP;    end
            default:     begin w_key_is_dir = 1'b0; w_key_dir = c_DIR_RIGHT; end
        endcase
    end

    // Reversal is judged against the committed direction, not the queued one.
    assign w_key_ok    = i_key_valid && (r_state != c_ST_INIT) && w_key_is_dir
                         && (w_key_dir != {r_dir[1], ~r_dir[0]});
    assign w_key_space = i_key_valid && (i_key_code == c_KEY_SPACE);
    assign w_key_enter = i_key_valid && (i_key_code == c_KEY_ENTER);

    always_comb begin
        w_nh_x = r_head_x;
        w_nh_y = r_head_y;
        w_wall = 1'b0;
        case (r_next_dir)
            c_DIR_RIGHT: if (r_head_x == c_X_MAX) w_wall = 1'b1; else w_nh_x = r_head_x + X_W'(1);
            c_DIR_LEFT:  if (r_head_x == '0)      w_wall = 1'b1; else w_nh_x = r_head_x - X_W'(1);
            c_DIR_DOWN:  if (r_head_y == c_Y_MAX) w_wall = 1'b1; else w_nh_y = r_head_y + Y_W'(1);
            default:     if (r_head_y == '0)      w_wall = 1'b1; else w_nh_y = r_head_y - Y_W'(1);
        endcase
    end

    // Without growth the tail cell is vacated by this step, so it is not scanned.
    assign w_grow_ok = r_grow_pend && (r_length < c_MAX_LEN);
    assign w_span    = w_grow_ok ? r_length : (r_length - L_W'(1));
    assign w_hit     = (r_scan != '0) && (r_chk_x == r_nh_x) && (r_chk_y == r_nh_y);
    assign w_busy    = (r_state == c_ST_INIT) || (r_state == c_ST_CHECK) || (r_state == c_ST_COMMIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT:   if (r_init_cnt == c_INIT_LAST) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:   if (w_key_ok) w_state_nxt = c_ST_RUN;
            c_ST_RUN: begin
                if (w_key_space)  w_state_nxt = c_ST_PAUSE;
                else if (i_tick)  w_state_nxt = w_wall ? c_ST_DEAD : c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (w_hit)                  w_state_nxt = c_ST_DEAD;
                else if (r_scan == w_span)  w_state_nxt = c_ST_COMMIT;
            end
            c_ST_COMMIT: w_state_nxt = c_ST_RUN;
            c_ST_PAUSE: begin
                if (w_key_enter)      w_state_nxt = c_ST_INIT;
                else if (w_key_space) w_state_nxt = c_ST_RUN;
            end
            c_ST_DEAD:   if (w_key_enter) w_state_nxt = c_ST_INIT;
            default:     w_state_nxt = c_ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_INIT;
            r_head_ptr  <= '0;
            r_length    <= '0;
            r_dir       <= c_DIR_RIGHT;
            r_next_dir  <= c_DIR_RIGHT;
            r_grow_pend <= 1'b0;
            r_init_cnt  <= '0;
            r_scan      <= '0;
            r_nh_x      <= '0;
            r_nh_y      <= '0;
            r_head_x    <= '0;
            r_head_y    <= '0;
            r_step_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
            r_running   <= 1'b0;
            r_dead      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_done <= 1'b0;
            r_overrun   <= i_tick && w_busy;
            r_busy      <= (w_state_nxt == c_ST_INIT) || (w_state_nxt == c_ST_CHECK)
                           || (w_state_nxt == c_ST_COMMIT);
            r_running   <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_CHECK)
                           || (w_state_nxt == c_ST_COMMIT);
            r_dead      <= (w_state_nxt == c_ST_DEAD);
            if (i_grow) r_grow_pend <= 1'b1;
            if (w_key_ok) r_next_dir <= w_key_dir;
            case (r_state)
                c_ST_INIT: begin
                    r_init_cnt <= r_init_cnt + L_W'(1);
                    r_length   <= r_init_cnt + L_W'(1);
                    if (r_init_cnt == '0) begin
                        r_head_x <= c_CX;
                        r_head_y <= c_CY;
                    end
                end
                c_ST_RUN: begin
                    if (i_tick && !w_key_space) begin
                        r_nh_x <= w_nh_x;
                        r_nh_y <= w_nh_y;
                        r_scan <= '0;
                    end
                end
                c_ST_CHECK: r_scan <= r_scan + L_W'(1);
                c_ST_COMMIT: begin
                    r_head_ptr  <= r_head_ptr - P_W'(1);
                    r_head_x    <= r_nh_x;
                    r_head_y    <= r_nh_y;
                    r_dir       <= r_next_dir;
                    r_step_done <= 1'b1;
                    if (w_grow_ok) r_length <= r_length + L_W'(1);
                    // A request landing on this cycle survives for the next step.
                    r_grow_pend <= i_grow;
                end
                c_ST_PAUSE, c_ST_DEAD: begin
                    if (w_key_enter) begin
                        r_init_cnt  <= '0;
                        r_head_ptr  <= '0;
                        r_length    <= '0;
                        r_dir       <= c_DIR_RIGHT;
                        r_next_dir  <= c_DIR_RIGHT;
                        r_grow_pend <= i_grow;
                    end
                end
                default: begin
                    r_scan <= r_scan;
                end
            endcase
        end
    end

    assign w_wr_en    = (r_state == c_ST_INIT) || (r_state == c_ST_COMMIT);
    assign w_wr_addr  = (r_state == c_ST_INIT) ? r_init_cnt[P_W-1:0] : (r_head_ptr - P_W'(1));
    assign w_wr_x     = (r_state == c_ST_INIT) ? (c_CX - X_W'(r_init_cnt)) : r_nh_x;
    assign w_wr_y     = (r_state == c_ST_INIT) ? c_CY : r_nh_y;
    assign w_chk_addr = r_head_ptr + r_scan[P_W-1:0];
    assign w_rd_addr  = r_head_ptr + i_rd_idx[P_W-1:0];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_x[w_wr_addr] <= w_wr_x;
            r_mem_y[w_wr_addr] <= w_wr_y;
        end
        r_chk_x <= r_mem_x[w_chk_addr];
        r_chk_y <= r_mem_y[w_chk_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_x     <= r_mem_x[w_rd_addr];
            r_rd_y     <= r_mem_y[w_rd_addr];
            r_rd_valid <= (i_rd_idx < r_length);
        end
    end

    assign o_rd_x      = r_rd_x;
    assign o_rd_y      = r_rd_y;
    assign o_rd_valid  = r_rd_valid;
    assign o_head_x    = r_head_x;
    assign o_head_y    = r_head_y;
    assign o_length    = r_length;
    assign o_running   = r_running;
    assign o_dead      = r_dead;
    assign o_busy      = r_busy;
    assign o_step_done = r_step_done;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_snake_body_engine
// Brief   : Self-checking bench: queue-based snake model feeds a scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_snake_body_engine;

    localparam int GW = 64;
    localparam int GH = 48;
    localparam int ML = 8;
    localparam int IL = 4;
    localparam int XW = 6;
    localparam int YW = 6;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_tick = 1'b0;
    logic          i_key_valid = 1'b0;
    logic [7:0]    i_key_code = 8'h00;
    logic          i_grow = 1'b0;
    logic [LW-1:0] i_rd_idx = '0;
    logic [XW-1:0] o_rd_x;
    logic [YW-1:0] o_rd_y;
    logic          o_rd_valid;
    logic [XW-1:0] o_head_x;
    logic [YW-1:0] o_head_y;
    logic [LW-1:0] o_length;
    logic          o_running;
    logic          o_dead;
    logic          o_busy;
    logic          o_step_done;
    logic          o_overrun;

    snake_body_engine #(
        .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL),
        .X_W(XW), .Y_W(YW), .L_W(LW)
    ) u_dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_key_valid(i_key_valid),
        .i_key_code(i_key_code), .i_grow(i_grow), .i_rd_idx(i_rd_idx),
        .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .o_rd_valid(o_rd_valid),
        .o_head_x(o_head_x), .o_head_y(o_head_y), .o_length(o_length),
        .o_running(o_running), .o_dead(o_dead), .o_busy(o_busy),
        .o_step_done(o_step_done), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hx;
        int hy;
        int len;
        int lat;
        bit dead;
    } exp_t;

    exp_t sb[$];
    int   mx[$];
    int   my[$];
    int   m_len;
    int   m_dir;
    int   m_ndir;
    bit   m_gp;
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic void model_init();
        mx.delete();
        my.delete();
        for (int i = 0; i < IL; i++) begin
            mx.push_back(GW / 2 - i);
            my.push_back(GH / 2);
        end
        m_len  = IL;
        m_dir  = 0;
        m_ndir = 0;
        m_gp   = 1'b0;
    endfunction

    function automatic void model_key(input logic [7:0] code);
        int d;
        d = -1;
        case (code)
            8'h74: d = 0;
            8'h6B: d = 1;
            8'h72: d = 2;
            8'h75: d = 3;
            default: d = -1;
        endcase
        if (d >= 0 && d != opposite(m_dir)) m_ndir = d;
    endfunction

    // lat counts clock edges from the edge that samples the tick.
    function automatic void model_step(output exp_t e);
        int nx, ny, span, hit;
        bit grow_ok;
        nx = mx[0];
        ny = my[0];
        case (m_ndir)
            0: nx++;
            1: nx--;
            2: ny++;
            default: ny--;
        endcase
        e.dead = 1'b0;
        e.lat  = 0;
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            e.dead = 1'b1;
        end else begin
            grow_ok = m_gp && (m_len < ML);
            span = grow_ok ? m_len : m_len - 1;
            hit = -1;
            for (int i = 0; i < span; i++)
                if (hit < 0 && mx[i] == nx && my[i] == ny) hit = i;
            if (hit >= 0) begin
                e.dead = 1'b1;
                e.lat  = hit + 2;
            end else begin
                e.lat = span + 2;
                mx.push_front(nx);
                my.push_front(ny);
                if (grow_ok) m_len++;
                else begin
                    void'(mx.pop_back());
                    void'(my.pop_back());
                end
                m_gp  = 1'b0;
                m_dir = m_ndir;
            end
        end
        e.hx  = mx[0];
        e.hy  = my[0];
        e.len = m_len;
    endfunction

    task automatic pulse_key(input logic [7:0] code);
        i_key_valid = 1'b1;
        i_key_code  = code;
        model_key(code);
        @(negedge clk);
        i_key_valid = 1'b0;
        i_key_code  = 8'h00;
    endtask

    task automatic pulse_grow();
        i_grow = 1'b1;
        m_gp   = 1'b1;
        @(negedge clk);
        i_grow = 1'b0;
    endtask

    task automatic do_step(input string tag, input bit extra);
        exp_t e;
        int   c;
        bit   got;
        model_step(e);
        sb.push_back(e);
        i_tick = 1'b1;
        c   = 0;
        got = 1'b0;
        while (!got && c < 200) begin
            @(negedge clk);
            c++;
            i_tick = extra && (c == 1);
            if (extra && c == 2) chk({tag, "_overrun"}, 64'(o_overrun), 64'd1);
            if (o_step_done || o_dead) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_lat"},  64'(c - 1),     64'(e.lat));
            chk({tag, "_dead"}, 64'(o_dead),    64'(e.dead));
            chk({tag, "_hx"},   64'(o_head_x),  64'(e.hx));
            chk({tag, "_hy"},   64'(o_head_y),  64'(e.hy));
            chk({tag, "_len"},  64'(o_length),  64'(e.len));
            if (!e.dead) begin
                @(negedge clk);
                chk({tag, "_sd_pulse"}, 64'(o_step_done), 64'd0);
            end
        end
    endtask

    task automatic watch(input bit tk, input int n, output int steps, output int ovr);
        steps = 0;
        ovr   = 0;
        i_tick = tk;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_tick = 1'b0;
            steps += int'(o_step_done);
            ovr   += int'(o_overrun);
        end
    endtask

    task automatic check_body(input string tag);
        for (int i = 0; i <= m_len; i++) begin
            i_rd_idx = LW'(i);
            @(negedge clk);
            chk($sformatf("%s_v%0d", tag, i), 64'(o_rd_valid), 64'(i < m_len));
            if (i < m_len) begin
                chk($sformatf("%s_x%0d", tag, i), 64'(o_rd_x), 64'(mx[i]));
                chk($sformatf("%s_y%0d", tag, i), 64'(o_rd_y), 64'(my[i]));
            end
        end
        i_rd_idx = '0;
    endtask

    task automatic restart(input string tag);
        pulse_key(8'h5A);
        chk({tag, "_busy_init"}, 64'(o_busy), 64'd1);
        chk({tag, "_dead_clr"},  64'(o_dead), 64'd0);
        model_init();
        repeat (IL + 1) @(negedge clk);
        chk({tag, "_len"},  64'(o_length), 64'(IL));
        chk({tag, "_busy"}, 64'(o_busy),   64'd0);
        chk({tag, "_hx"},   64'(o_head_x), 64'(GW / 2));
        chk({tag, "_hy"},   64'(o_head_y), 64'(GH / 2));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps, ovr;
        model_init();
        repeat (3) @(negedge clk);
        chk("rst_len",  64'(o_length), 64'd0);
        chk("rst_flag", 64'({o_busy, o_dead, o_running, o_step_done, o_overrun, o_rd_valid}), 64'd0);
        chk("rst_head", 64'({o_head_x, o_head_y}), 64'd0);
        rst = 1'b0;
        repeat (IL + 1) @(negedge clk);
        chk("init_len",  64'(o_length),  64'(IL));
        chk("init_hx",   64'(o_head_x),  64'(GW / 2));
        chk("init_hy",   64'(o_head_y),  64'(GH / 2));
        chk("init_busy", 64'(o_busy),    64'd0);
        chk("init_run",  64'(o_running), 64'd0);
        check_body("init_body");

        // A tick while waiting for the first key is ignored.
        watch(1'b1, 6, steps, ovr);
        chk("wait_tick", 64'(steps), 64'd0);
        pulse_key(8'h74);
        chk("start_run", 64'(o_running), 64'd1);
        do_step("step1", 1'b0);
        pulse_key(8'h6B);
        do_step("reverse", 1'b0);

        // Square loop: the last two steps enter the vacating tail cell.
        pulse_key(8'h75); do_step("sq_up", 1'b0);
        pulse_key(8'h6B); do_step("sq_left", 1'b0);
        pulse_key(8'h72); do_step("tail_down", 1'b0);
        pulse_key(8'h74); do_step("tail_right", 1'b0);

        pulse_grow();
        do_step("grow", 1'b0);
        check_body("grow_body");

        pulse_key(8'h29);
        chk("pause_run", 64'(o_running), 64'd0);
        watch(1'b1, 8, steps, ovr);
        chk("pause_steps", 64'(steps), 64'd0);
        chk("pause_ovr",   64'(ovr),   64'd0);
        chk("pause_hx",    64'(o_head_x), 64'(mx[0]));
        pulse_key(8'h29);
        chk("resume_run", 64'(o_running), 64'd1);

        pulse_key(8'h75); do_step("ovr_up", 1'b1);
        watch(1'b0, 12, steps, ovr);
        chk("ovr_one_step", 64'(steps), 64'd0);
        pulse_key(8'h6B); do_step("body_left", 1'b0);
        pulse_key(8'h72); do_step("body_hit", 1'b0);
        chk("body_run", 64'(o_running), 64'd0);
        watch(1'b1, 8, steps, ovr);
        chk("dead_steps", 64'(steps), 64'd0);
        chk("dead_hold",  64'(o_dead), 64'd1);
        check_body("dead_body");

        restart("rs1");
        check_body("rs1_body");
        pulse_key(8'h74);
        for (int i = 0; i < ML - IL; i++) begin
            pulse_grow();
            do_step($sformatf("fill%0d", i), 1'b0);
        end
        pulse_grow();
        do_step("full_grow", 1'b0);
        do_step("full_next", 1'b0);
        check_body("full_body");
        while (mx[0] < GW - 1) do_step("to_wall", 1'b0);
        do_step("wall", 1'b0);
        chk("wall_run", 64'(o_running), 64'd0);

        restart("rs2");
        pulse_key(8'h74);
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        chk("mid_busy", 64'(o_busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_len",  64'(o_length), 64'd0);
        chk("arst_flag", 64'({o_busy, o_dead, o_running, o_step_done, o_overrun, o_rd_valid}), 64'd0);
        chk("arst_pos",  64'({o_head_x, o_head_y, o_rd_x, o_rd_y}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
